siu_conv_arbiter: RTL and testbench

- Shares one sign-magnitude to two's-complement conversion datapath among NUM_REQ synaptic-input requesters inside the SIU.
- Each requester presents a magnitude/sign pair with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle.
- The converted word is registered into a single-entry output stage, tagged with the winning requester's ID, and drained by a downstream valid/ready consumer.

---
 rtl/siu_conv_arbiter.sv | 145 ++++++++++++++
 tb/tb_siu_conv_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/siu_conv_arbiter.sv
// siu_conv_arbiter: round-robin arbiter sharing one sign-magnitude to
// two's-complement converter among NUM_REQ requesters, with a single-entry
// registered output stage drained by a valid/ready consumer.
// Optional build macro SIU_CONV_SAT_EN: saturate to the signed DATA_W range
// and expose a sticky sat_flag output.
module siu_conv_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_mag,
  input  logic [NUM_REQ-1:0]        req_sign,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
`ifdef SIU_CONV_SAT_EN
  output logic                      sat_flag,
`endif
  output logic                      busy
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [DATA_W-1:0]   sel_mag;
  logic                sel_sign;
  logic [DATA_W-1:0]   conv_val;
  logic                can_accept;
  logic                xfer;

`ifdef SIU_CONV_SAT_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic sat_flag_q, sat_flag_d;
  logic conv_sat;
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Winner operand select and conversion
  always_comb begin
    sel_mag  = req_mag[32'(grant_id) * DATA_W +: DATA_W];
    sel_sign = req_sign[grant_id];
    conv_val = sel_sign ? (~sel_mag + DATA_W'(1)) : sel_mag;
`ifdef SIU_CONV_SAT_EN
    conv_sat = 1'b0;
    if (!sel_sign && (sel_mag > MAX_POS)) begin
      conv_val = MAX_POS;
      conv_sat = 1'b1;
    end else if (sel_sign && (sel_mag > MIN_NEG)) begin
      conv_val = MIN_NEG;
      conv_sat = 1'b1;
    end
`endif
  end

  // Handshake: accept only when the output stage is empty or draining
  always_comb begin
    can_accept = (state_q == S_EMPTY) | out_ready;
    xfer       = grant_found & can_accept & rst_n;
    req_ready  = xfer ? (NUM_REQ'(1) << grant_id) : '0;
  end

  // Output-stage next state, result capture and pointer advance
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef SIU_CONV_SAT_EN
    sat_flag_d = sat_flag_q;
`endif
    if (xfer) begin
      state_d    = S_FULL;
      out_data_d = conv_val;
      out_id_d   = grant_id;
      rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`ifdef SIU_CONV_SAT_EN
      sat_flag_d = sat_flag_q | conv_sat;
`endif
    end else if ((state_q == S_FULL) && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      rr_ptr_q   <= '0;
`ifdef SIU_CONV_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef SIU_CONV_SAT_EN
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = out_valid | (|req_valid);
`ifdef SIU_CONV_SAT_EN
  assign sat_flag  = sat_flag_q;
`endif

endmodule

// File: tb/tb_siu_conv_arbiter.sv
// Bench for siu_conv_arbiter: per-cycle vector table with hand-derived
// ready patterns, a reference model for arbitration, and a scoreboard of
// expected results popped as the output stage drains.
module tb_siu_conv_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_mag;
  logic [NR-1:0]     req_sign;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic              out_ready;
  logic              busy;
`ifdef SIU_CONV_SAT_EN
  logic              sat_flag;
`endif

  siu_conv_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_mag   (req_mag),
    .req_sign  (req_sign),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
`ifdef SIU_CONV_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*DW-1:0] mag;
    logic [NR-1:0]    sign;
    logic             ordy;
    logic [NR-1:0]    exp_ready;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } sb_t;

  vec_t  vecs[$];
  sb_t   sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // reference model state
  logic          m_valid = 1'b0;
  int            m_rr    = 0;
  logic          m_sat   = 1'b0;
  logic [NR-1:0] pend    = '0;
  logic [DW-1:0] pend_mag [NR];
  logic [NR-1:0] pend_sign = '0;

  function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR*DW-1:0] m,
                              input logic [NR-1:0] s, input logic o,
                              input logic [NR-1:0] e);
    vec_t r;
    r.valid = v; r.mag = m; r.sign = s; r.ordy = o; r.exp_ready = e;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_conv(input logic [DW-1:0] m, input logic s,
                                             output logic sat);
    sat = 1'b0;
`ifdef SIU_CONV_SAT_EN
    if (!s && m > 8'h7F) begin sat = 1'b1; return 8'h7F; end
    if (s && m > 8'h80)  begin sat = 1'b1; return 8'h80; end
`endif
    return s ? 8'(8'h00 - m) : m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_valid = 1'b0; m_rr = 0; m_sat = 1'b0; pend = '0;
    sb.delete();
  endtask

  // One cycle: drive, compare against model/table, then advance the model
  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] m,
                      input logic [NR-1:0] s, input logic ordy,
                      input logic [NR-1:0] exp_rdy, input bit use_exp);
    logic [NR-1:0] mrdy;
    int            g;
    bit            found;
    bit            can;
    logic          sat;
    sb_t           e;
    @(negedge clk);
    req_valid = v; req_mag = m; req_sign = s; out_ready = ordy;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (pend[i]) begin
        check($sformatf("protocol_req%0d", i), {23'd0, v[i], m[i*DW +: DW]}, {23'd0, 1'b1, pend_mag[i]});
        check($sformatf("protocol_sign%0d", i), 32'(s[i]), 32'(pend_sign[i]));
      end
    end
    found = 1'b0; g = 0;
    for (int k = 0; k < NR; k++) begin
      if (!found && v[(m_rr + k) % NR]) begin
        found = 1'b1; g = (m_rr + k) % NR;
      end
    end
    can  = !m_valid || ordy;
    mrdy = (found && can) ? NR'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(mrdy));
    if (use_exp) check("table_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(sb[0].data));
      check("out_id", 32'(out_id), 32'(sb[0].id));
    end
    check("busy", 32'(busy), 32'(m_valid | (|v)));
`ifdef SIU_CONV_SAT_EN
    check("sat_flag", 32'(sat_flag), 32'(m_sat));
`endif
    for (int i = 0; i < NR; i++) begin
      pend[i]      = v[i] && !mrdy[i];
      pend_mag[i]  = m[i*DW +: DW];
      pend_sign[i] = s[i];
    end
    if (m_valid && ordy) begin
      void'(sb.pop_front());
      m_valid = 1'b0;
    end
    if (found && can) begin
      e.data = ref_conv(m[g*DW +: DW], s[g], sat);
      e.id   = IW'(g);
      sb.push_back(e);
      m_valid = 1'b1;
      m_rr    = (g + 1) % NR;
      m_sat   = m_sat | sat;
    end
  endtask

  initial begin
    // mag packing is {m3, m2, m1, m0}
    vecs.push_back(mk(4'b0100, {8'h00, 8'h05, 8'h00, 8'h00}, 4'b0100, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b0000, '0, 4'b0000, 1'b1, 4'b0000));
    vecs.push_back(mk(4'b1000, {8'h23, 8'h00, 8'h00, 8'h00}, 4'b0000, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b1111, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b1111, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0010));
    vecs.push_back(mk(4'b1111, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b1111, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b1111, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b1110, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0010));
    vecs.push_back(mk(4'b1100, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b1000, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b0101, 1'b1, 4'b1000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b1010, {8'h33, 8'h00, 8'h31, 8'h00}, 4'b0010, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b1010, {8'h33, 8'h00, 8'h31, 8'h00}, 4'b0010, 1'b1, 4'b0010));
    vecs.push_back(mk(4'b1000, {8'h33, 8'h00, 8'h31, 8'h00}, 4'b0010, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b0001, {8'h00, 8'h00, 8'h00, 8'h10}, 4'b0000, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b0000, '0, 4'b0000, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b0000, '0, 4'b0000, 1'b1, 4'b0000));
    vecs.push_back(mk(4'b0001, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0001, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b0010, {8'h00, 8'h00, 8'h80, 8'h00}, 4'b0010, 1'b1, 4'b0010));
    vecs.push_back(mk(4'b0100, {8'h00, 8'hC8, 8'h00, 8'h00}, 4'b0000, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b1000, {8'hC8, 8'h00, 8'h00, 8'h00}, 4'b1000, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b0000, '0, 4'b0000, 1'b1, 4'b0000));

    // reset with requests pending: req_ready must stay low
    rst_n = 1'b0; req_valid = 4'b1111; req_mag = '0; req_sign = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    reset_model();

    foreach (vecs[i])
      step(vecs[i].valid, vecs[i].mag, vecs[i].sign, vecs[i].ordy, vecs[i].exp_ready, 1'b1);

    // Fixed conversion corners from the last table block
    // (queued results already checked through the scoreboard)

    // Reset while FULL with req 3 pending and rr_ptr moved to 2
    step(4'b0010, {8'h00, 8'h00, 8'h41, 8'h00}, 4'b0000, 1'b1, 4'b0010, 1'b1);
    step(4'b1000, {8'h43, 8'h00, 8'h00, 8'h00}, 4'b1000, 1'b0, 4'b0000, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    reset_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(4'b1010, {8'h43, 8'h00, 8'h41, 8'h00}, 4'b1000, 1'b1, 4'b0010, 1'b1);
    step(4'b1000, {8'h43, 8'h00, 8'h41, 8'h00}, 4'b1000, 1'b1, 4'b1000, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1, 4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
